muldiv_seq_ctrl: RTL and testbench
==================================

# muldiv_seq_ctrl

Sequencer for the RV32M execute path. It accepts one M-extension operation at a time from the execute stage and decodes funct3 into a multiply or a divide. It drives the radix-8 multiplier (`mult_radix8_top`) or the divider through their enable/finish handshakes, and stalls the pipeline until the result is registered. Divide-by-zero and signed overflow are resolved locally per the RISC-V spec without starting the divider. A watchdog bounds every operation.

## Interface
Parameters:
- `XLEN`, 32, operand/result width
- `TIMEOUT`, 64, max cycles waiting for a unit FINISH before abort (≥2)

Ports:
- `CLK` in 1: rising-edge clock
- `RST_N` in 1: reset, asynchronous, active-low (one clock; reset is asynchronous and active-low)
- `MD_VALID` in 1: execute stage presents an M op; held with operands until `MD_DONE`
- `MD_FUCT3` in 3: RV32M funct3 (0–3 MUL/MULH/MULHSU/MULHU, 4–7 DIV/DIVU/REM/REMU)
- `MD_OPER_A`, `MD_OPER_B` in XLEN: rs1, rs2 values
- `MD_KILL` in 1: pipeline flush; abort the current op
- `MD_STALL` out 1: hold the pipeline
- `MD_DONE` out 1: one-cycle pulse; `MD_RESULT` valid
- `MD_RESULT` out XLEN: registered result
- `MD_ERR` out 1: with `MD_DONE`, the op ended by timeout
- `MULT_OPER_A`, `MULT_OPER_B` out XLEN; `MULT_FUCT3` out 2 (funct3[1:0]); `ENABLE_MULT` out 1
- `MULT_O` in XLEN; `MULT_FINISH` in 1
- `DIV_OPER_A`, `DIV_OPER_B` out XLEN; `DIV_FUCT3` out 2; `ENABLE_DIV` out 1
- `DIV_O` in XLEN; `DIV_FINISH` in 1

## Operation
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- IDLE with `MD_VALID`=1 and `MD_KILL`=0: latch operands and funct3.
  - funct3[2]=0 → MUL_RUN.
  - funct3[2]=1 with `MD_OPER_B`=0 → DONE. Result: DIV/DIVU all ones; REM/REMU = A.
  - funct3=DIV/REM with A=0x8000_0000 and B=0xFFFF_FFFF → DONE. DIV result 0x8000_0000; REM result 0.
  - Otherwise → DIV_RUN.
- MUL_RUN/DIV_RUN:
  - `ENABLE_*` is held at 1 and unit operands/funct3 are driven from the latched registers.
  - FINISH sampled 1 → capture unit output into `MD_RESULT` → DONE.
- Watchdog counter clears on entry to a RUN state. Reaching TIMEOUT without FINISH → DONE with `MD_ERR`=1 and `MD_RESULT`=all ones.
- DONE: `MD_DONE`=1 for exactly one cycle, then → IDLE unconditionally. The op on `MD_VALID` during DONE is the completing one and is not re-accepted.
- `MD_KILL`=1 in any state → IDLE next cycle.
  - Enables drop and `MD_DONE` is not asserted.
  - `MD_KILL` beats a FINISH arriving in the same cycle.
- `MD_STALL` = (IDLE & `MD_VALID` & ~`MD_KILL`) | MUL_RUN | DIV_RUN. Combinational; low in DONE.
- Unit operand outputs are 0 and `ENABLE_*`=0 whenever the unit is not running.

## Timing
- Reset values: state IDLE; `MD_STALL`, `MD_DONE`, `MD_ERR`, `ENABLE_MULT`, `ENABLE_DIV` = 0; all data outputs = 0. The counter clears. Reset mid-operation drops the enables immediately (asynchronously).
- Accept at edge 0. `ENABLE_*` is high from cycle 1 until the cycle FINISH is sampled, inclusive.
- `MD_DONE` is asserted in the cycle after FINISH is sampled. Total latency = unit latency + 2.
- Shortcut ops (div-by-0, overflow): `MD_DONE` in cycle 1. Latency 2 including the accept edge.
- `MD_RESULT` is held stable after DONE until the next capture.
- FINISH is ignored outside its matching RUN state.

## Structure
- Shared package `muldiv_pkg`:
  - funct3 localparams (MUL..REMU)
  - state encoding
  - INT_MIN constant
- Sub-module `muldiv_special_case` (combinational): div-by-0/overflow detection and shortcut result.
- The FSM, latches and watchdog stay in the top.

## Test plan
- MUL A=3, B=8, model FINISH after 4 cycles → `ENABLE_MULT` high 4 cycles; `MD_DONE` one cycle later; `MD_RESULT`=24; `MD_STALL` low in the DONE cycle.
- MULH A=−8, B=−3 → `MULT_FUCT3`=1 and operands passed unchanged; result from `MULT_O` captured exactly.
- DIVU A=234, B=0 → no `ENABLE_DIV`; `MD_DONE` at cycle 1; result 0xFFFF_FFFF. REMU same operands → 234.
- DIV A=0x8000_0000, B=−1 → result 0x8000_0000, no enable. REM with the same operands → 0.
- DIV running, `MD_KILL` in the same cycle as `DIV_FINISH` → no `MD_DONE`; IDLE next cycle; a new MUL 555×555 then completes with result 308025.
- Divider never finishes, TIMEOUT=64 → `MD_DONE`=1 with `MD_ERR`=1 and result 0xFFFF_FFFF after 64 run cycles. Assert `RST_N` mid-run in a second pass → enables 0 immediately.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer: funct3 codes,
// FSM state encoding and the most negative 32-bit integer.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MUL_RUN = 2'd1;
  localparam logic [1:0] ST_DIV_RUN = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/muldiv_special_case.sv
// Detects divide ops that never need the divider (divide-by-zero, signed
// overflow) and produces the architecturally defined result for them.
module muldiv_special_case
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      fn_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            hit_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  logic is_rem;
  logic is_signed;
  logic div_zero;
  logic overflow;

  assign is_rem    = (fn_i == F3_REM) | (fn_i == F3_REMU);
  assign is_signed = (fn_i == F3_DIV) | (fn_i == F3_REM);
  assign div_zero  = fn_i[2] & (b_i == '0);
  // Divide-by-zero takes priority; the two cases cannot overlap anyway.
  assign overflow  = is_signed & (a_i == MinVal) & (b_i == '1);
  assign hit_o     = div_zero | overflow;

  always_comb begin
    result_o = '0;
    if (div_zero) begin
      result_o = is_rem ? a_i : '1;
    end else if (overflow) begin
      result_o = is_rem ? '0 : MinVal;
    end
  end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// RV32M execute sequencer: accepts one M op, runs the multiplier or divider
// through its enable/finish handshake, stalls the pipe and bounds each op.
module muldiv_seq_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            MD_VALID,
  input  logic [2:0]      MD_FUCT3,
  input  logic [XLEN-1:0] MD_OPER_A,
  input  logic [XLEN-1:0] MD_OPER_B,
  input  logic            MD_KILL,
  output logic            MD_STALL,
  output logic            MD_DONE,
  output logic [XLEN-1:0] MD_RESULT,
  output logic            MD_ERR,
  output logic [XLEN-1:0] MULT_OPER_A,
  output logic [XLEN-1:0] MULT_OPER_B,
  output logic [1:0]      MULT_FUCT3,
  output logic            ENABLE_MULT,
  input  logic [XLEN-1:0] MULT_O,
  input  logic            MULT_FINISH,
  output logic [XLEN-1:0] DIV_OPER_A,
  output logic [XLEN-1:0] DIV_OPER_B,
  output logic [1:0]      DIV_FUCT3,
  output logic            ENABLE_DIV,
  input  logic [XLEN-1:0] DIV_O,
  input  logic            DIV_FINISH
);

  localparam int CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic [1:0]      fn_q, fn_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            sc_hit;
  logic [XLEN-1:0] sc_result;
  logic            mul_run;
  logic            div_run;

  muldiv_special_case #(
    .XLEN(XLEN)
  ) u_special_case (
    .fn_i    (MD_FUCT3),
    .a_i     (MD_OPER_A),
    .b_i     (MD_OPER_B),
    .hit_o   (sc_hit),
    .result_o(sc_result)
  );

  always_comb begin
    state_d = state_q;
    fn_d    = fn_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    // A flush wins over everything, including a same-cycle FINISH.
    if (MD_KILL) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (MD_VALID) begin
            fn_d  = MD_FUCT3[1:0];
            a_d   = MD_OPER_A;
            b_d   = MD_OPER_B;
            err_d = 1'b0;
            cnt_d = '0;
            if (!MD_FUCT3[2]) begin
              state_d = ST_MUL_RUN;
            end else if (sc_hit) begin
              res_d   = sc_result;
              state_d = ST_DONE;
            end else begin
              state_d = ST_DIV_RUN;
            end
          end
        end
        ST_MUL_RUN: begin
          if (MULT_FINISH) begin
            res_d   = MULT_O;
            state_d = ST_DONE;
          end else if (cnt_q == CntLast) begin
            res_d   = '1;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        ST_DIV_RUN: begin
          if (DIV_FINISH) begin
            res_d   = DIV_O;
            state_d = ST_DONE;
          end else if (cnt_q == CntLast) begin
            res_d   = '1;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      fn_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fn_q    <= fn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Unit-facing outputs decode straight from state so reset drops them at once.
  assign mul_run = (state_q == ST_MUL_RUN);
  assign div_run = (state_q == ST_DIV_RUN);

  assign ENABLE_MULT = mul_run;
  assign MULT_OPER_A = mul_run ? a_q : '0;
  assign MULT_OPER_B = mul_run ? b_q : '0;
  assign MULT_FUCT3  = mul_run ? fn_q : 2'b00;

  assign ENABLE_DIV  = div_run;
  assign DIV_OPER_A  = div_run ? a_q : '0;
  assign DIV_OPER_B  = div_run ? b_q : '0;
  assign DIV_FUCT3   = div_run ? fn_q : 2'b00;

  assign MD_STALL  = ((state_q == ST_IDLE) & MD_VALID & ~MD_KILL) | mul_run | div_run;
  assign MD_DONE   = (state_q == ST_DONE);
  assign MD_ERR    = (state_q == ST_DONE) & err_q;
  assign MD_RESULT = res_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Scoreboard bench for muldiv_seq_ctrl with behavioural multiplier/divider
// models of configurable latency.
module tb_muldiv_seq_ctrl;
  import muldiv_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        MD_VALID = 1'b0;
  logic [2:0]  MD_FUCT3 = 3'd0;
  logic [31:0] MD_OPER_A = '0;
  logic [31:0] MD_OPER_B = '0;
  logic        MD_KILL = 1'b0;
  logic        MD_STALL, MD_DONE, MD_ERR;
  logic [31:0] MD_RESULT;
  logic [31:0] MULT_OPER_A, MULT_OPER_B, MULT_O;
  logic [1:0]  MULT_FUCT3;
  logic        ENABLE_MULT, MULT_FINISH;
  logic [31:0] DIV_OPER_A, DIV_OPER_B, DIV_O;
  logic [1:0]  DIV_FUCT3;
  logic        ENABLE_DIV, DIV_FINISH;

  muldiv_seq_ctrl #(.XLEN(32), .TIMEOUT(64)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .MD_VALID(MD_VALID), .MD_FUCT3(MD_FUCT3),
    .MD_OPER_A(MD_OPER_A), .MD_OPER_B(MD_OPER_B), .MD_KILL(MD_KILL),
    .MD_STALL(MD_STALL), .MD_DONE(MD_DONE), .MD_RESULT(MD_RESULT), .MD_ERR(MD_ERR),
    .MULT_OPER_A(MULT_OPER_A), .MULT_OPER_B(MULT_OPER_B), .MULT_FUCT3(MULT_FUCT3),
    .ENABLE_MULT(ENABLE_MULT), .MULT_O(MULT_O), .MULT_FINISH(MULT_FINISH),
    .DIV_OPER_A(DIV_OPER_A), .DIV_OPER_B(DIV_OPER_B), .DIV_FUCT3(DIV_FUCT3),
    .ENABLE_DIV(ENABLE_DIV), .DIV_O(DIV_O), .DIV_FINISH(DIV_FINISH)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] res;
    logic        err;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  // Execution-unit models
  int mult_lat = 4;
  int div_lat = 3;
  bit div_never = 1'b0;
  int mcnt = 0;
  int dcnt = 0;

  function automatic logic [31:0] mul_model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      2'd0: p = ua * ub;
      2'd1: p = sa * sb;
      2'd2: p = sa * ub;
      default: p = ua * ub;
    endcase
    return (f == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] div_model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 32'hFFFF_FFFF;
    case (f)
      2'd0: return $signed(a) / $signed(b);
      2'd1: return a / b;
      2'd2: return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  always @(posedge CLK) begin
    mcnt <= ENABLE_MULT ? mcnt + 1 : 0;
    dcnt <= ENABLE_DIV ? dcnt + 1 : 0;
  end

  always_comb begin
    MULT_FINISH = ENABLE_MULT && (mcnt == mult_lat - 1);
    DIV_FINISH  = ENABLE_DIV && !div_never && (dcnt == div_lat - 1);
    MULT_O      = mul_model(MULT_FUCT3, MULT_OPER_A, MULT_OPER_B);
    DIV_O       = div_model(DIV_FUCT3, DIV_OPER_A, DIV_OPER_B);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every MD_DONE pulse must match the oldest expected response.
  always @(negedge CLK) begin
    exp_t e;
    if (RST_N && MD_DONE) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got MD_DONE=1 result %h, expected no completion", MD_RESULT);
      end else begin
        e = sb_q.pop_front();
        $display("done %s: result=%h err=%b (expected %h/%b)", e.name, MD_RESULT, MD_ERR, e.res, e.err);
        chk({e.name, "_result"}, MD_RESULT, e.res);
        chk({e.name, "_err"}, 32'(MD_ERR), 32'(e.err));
        chk({e.name, "_stall_in_done"}, 32'(MD_STALL), 32'd0);
      end
    end
  end

  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_err, input int exp_lat, input int exp_en);
    int cyc;
    int en_cnt;
    bit seen;
    bit first;
    cyc = 0;
    en_cnt = 0;
    seen = 1'b0;
    first = 1'b1;
    @(negedge CLK);
    MD_FUCT3 = f3;
    MD_OPER_A = a;
    MD_OPER_B = b;
    MD_VALID = 1'b1;
    sb_q.push_back('{exp_res, exp_err, nm});
    #1 chk({nm, "_stall_accept"}, 32'(MD_STALL), 32'd1);
    while (!seen && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      if (ENABLE_MULT || ENABLE_DIV) begin
        en_cnt++;
        if (first) begin
          first = 1'b0;
          chk({nm, "_unit_is_div"}, 32'(ENABLE_DIV), 32'(f3[2]));
          chk({nm, "_stall_run"}, 32'(MD_STALL), 32'd1);
          if (ENABLE_MULT) begin
            chk({nm, "_mult_a"}, MULT_OPER_A, a);
            chk({nm, "_mult_b"}, MULT_OPER_B, b);
            chk({nm, "_mult_f3"}, 32'(MULT_FUCT3), 32'(f3[1:0]));
            chk({nm, "_div_a_idle"}, DIV_OPER_A, 32'd0);
          end else begin
            chk({nm, "_div_a"}, DIV_OPER_A, a);
            chk({nm, "_div_b"}, DIV_OPER_B, b);
            chk({nm, "_div_f3"}, 32'(DIV_FUCT3), 32'(f3[1:0]));
            chk({nm, "_mult_a_idle"}, MULT_OPER_A, 32'd0);
          end
        end
      end
      if (MD_DONE) seen = 1'b1;
    end
    MD_VALID = 1'b0;
    chk({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({nm, "_enable_cycles"}, 32'(en_cnt), 32'(exp_en));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    #12;
    chk("rst_stall", 32'(MD_STALL), 32'd0);
    chk("rst_done", 32'(MD_DONE), 32'd0);
    chk("rst_err", 32'(MD_ERR), 32'd0);
    chk("rst_result", MD_RESULT, 32'd0);
    chk("rst_enables", {30'd0, ENABLE_MULT, ENABLE_DIV}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    mult_lat = 4;
    div_lat = 3;
    run_op("mul_3x8", F3_MUL, 32'd3, 32'd8, 32'd24, 1'b0, 5, 4);
    run_op("mulh_m8xm3", F3_MULH, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'h0000_0000, 1'b0, 5, 4);
    run_op("mulhu_big", F3_MULHU, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFF5, 1'b0, 5, 4);
    run_op("divu_by0", F3_DIVU, 32'd234, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, 0);
    run_op("remu_by0", F3_REMU, 32'd234, 32'd0, 32'd234, 1'b0, 1, 0);
    run_op("div_ovf", F3_DIV, INT_MIN, 32'hFFFF_FFFF, INT_MIN, 1'b0, 1, 0);
    run_op("rem_ovf", F3_REM, INT_MIN, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, 0);
    run_op("divu_100_7", F3_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 4, 3);
    run_op("div_m100_7", F3_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 4, 3);

    // Kill in the same cycle the divider finishes
    @(negedge CLK);
    MD_FUCT3 = F3_DIVU;
    MD_OPER_A = 32'd100;
    MD_OPER_B = 32'd7;
    MD_VALID = 1'b1;
    repeat (3) @(negedge CLK);
    chk("kill_finish_same_cycle", 32'(DIV_FINISH), 32'd1);
    MD_KILL = 1'b1;
    MD_VALID = 1'b0;
    @(negedge CLK);
    MD_KILL = 1'b0;
    chk("kill_enable_dropped", 32'(ENABLE_DIV), 32'd0);
    chk("kill_no_done", 32'(MD_DONE), 32'd0);
    chk("kill_stall_low", 32'(MD_STALL), 32'd0);
    repeat (3) @(negedge CLK);
    run_op("mul_555x555", F3_MUL, 32'd555, 32'd555, 32'd308025, 1'b0, 5, 4);

    // Watchdog: divider never finishes
    div_never = 1'b1;
    run_op("div_timeout", F3_DIVU, 32'd100, 32'd7, 32'hFFFF_FFFF, 1'b1, 65, 64);
    chk("result_held_after_done", MD_RESULT, 32'hFFFF_FFFF);

    // Asynchronous reset mid-run
    @(negedge CLK);
    MD_FUCT3 = F3_DIVU;
    MD_OPER_A = 32'd100;
    MD_OPER_B = 32'd7;
    MD_VALID = 1'b1;
    repeat (10) @(negedge CLK);
    chk("pre_reset_enable", 32'(ENABLE_DIV), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst_enable", 32'(ENABLE_DIV), 32'd0);
    chk("async_rst_div_a", DIV_OPER_A, 32'd0);
    chk("async_rst_done", 32'(MD_DONE), 32'd0);
    chk("async_rst_result", MD_RESULT, 32'd0);
    MD_VALID = 1'b0;
    div_never = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    run_op("mul_after_reset", F3_MUL, 32'd7, 32'd6, 32'd42, 1'b0, 5, 4);

    repeat (3) @(negedge CLK);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
